// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the control state encoding and the digit-counter sizing function.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Width of a counter that indexes n digits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
// Consumes DIGIT bits per clock, LSB digit first, carrying between digits in a flop.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             sub_q,       sub_d;
  logic             carry_q,     carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_c_msb;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_sum),
    .cout (dig_cout),
    .c_msb(dig_c_msb)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = WIDTH'({dig_sum, acc_q} >> DIGIT);
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Published outputs change only here, so they hold through DONE and IDLE.
          state_d     = DONE;
          result_d    = WIDTH'({dig_sum, acc_q} >> DIGIT);
          carry_out_d = dig_cout ^ sub_q;
          overflow_d  = dig_cout ^ dig_c_msb;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers
  // are reset too, so an aborted operation leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed corner cases on DIGIT=2 plus a
// random sweep run on DIGIT=1, 2 and 8 instances against an arithmetic reference.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sub = 1'b0;

  logic       in_valid1 = 1'b0, in_valid2 = 1'b0, in_valid8 = 1'b0;
  logic       out_ready1 = 1'b0, out_ready2 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready1, in_ready2, in_ready8;
  logic       out_valid1, out_valid2, out_valid8;
  logic [7:0] result1, result2, result8;
  logic       carry_out1, carry_out2, carry_out8;
  logic       overflow1, overflow2, overflow8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .carry_out(carry_out2), .overflow(overflow2)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .carry_out(carry_out1), .overflow(overflow1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry_out(carry_out8), .overflow(overflow8)
  );

  // Reference: returns {overflow, carry_out, result} from plain integer arithmetic.
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    logic [8:0] full;
    logic [7:0] r;
    logic       c;
    logic       v;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[7:0];
      c    = full[8];
      v    = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      r = x - y;
      c = (x < y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
    return {v, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation to the DIGIT=2 instance and returns edges until out_valid
  // (0 if it never rose within the bound).
  task automatic run_op2(input logic [7:0] x, input logic [7:0] y, input logic s,
                         output int lat);
    lat = 0;
    a = x; b = y; sub = s; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid2) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_result2();
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready2, out_valid2, result2, carry_out2, overflow2} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h c=%b v=%b, want rdy=1 vld=0 res=00 c=0 v=0",
               in_ready2, out_valid2, result2, carry_out2, overflow2);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    logic [7:0] va [4] = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
    logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] want [4] = '{{1'b1, 1'b0, 8'h80}, {1'b0, 1'b1, 8'h00},
                             {1'b0, 1'b1, 8'hFF}, {1'b1, 1'b0, 8'h7F}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op2(va[i], vb[i], vs[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d edges, want 4", i, lat);
      end
      checks++;
      if ({overflow2, carry_out2, result2} !== want[i]) begin
        errors++;
        $display("FAIL arith_result[%0d]: v=%b c=%b res=%h, want v=%b c=%b res=%h",
                 i, overflow2, carry_out2, result2, want[i][9], want[i][8], want[i][7:0]);
      end
      release_result2();
      checks++;
      if ({in_ready2, out_valid2} !== 2'b10) begin
        errors++;
        $display("FAIL arith_release[%0d]: rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready2, out_valid2);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op2(8'h55, 8'h22, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d edges, want 4", lat);
    end
    // Offer a fresh operation during DONE: it must not be taken.
    in_valid2 = 1'b1; a = 8'hAA; b = 8'hAA; sub = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({out_valid2, in_ready2, result2, carry_out2, overflow2} !== {1'b1, 1'b0, 8'h77, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h c=%b v=%b, want vld=1 rdy=0 res=77 c=0 v=0",
                 i, out_valid2, in_ready2, result2, carry_out2, overflow2);
      end
    end
    in_valid2 = 1'b0;
    release_result2();
    checks++;
    if ({in_ready2, out_valid2, result2} !== {1'b1, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=77", in_ready2, out_valid2, result2);
    end
    run_op2(8'h12, 8'h34, 1'b0, lat);
    checks++;
    if ({lat == 4, result2, carry_out2, overflow2} !== {1'b1, 8'h46, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d res=%h c=%b v=%b, want lat=4 res=46 c=0 v=0",
               lat, result2, carry_out2, overflow2);
    end
    release_result2();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [9:0] exp;
    a = 8'hA5; b = 8'h3C; sub = 1'b0; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid2, in_ready2, result2, carry_out2, overflow2} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: vld=%b rdy=%b res=%h c=%b v=%b, want vld=0 rdy=1 res=00 c=0 v=0",
               out_valid2, in_ready2, result2, carry_out2, overflow2);
    end
    tick();
    rst_n = 1'b1;
    tick();
    exp = ref_model(8'hC8, 8'h5A, 1'b1);
    run_op2(8'hC8, 8'h5A, 1'b1, lat);
    checks++;
    if ({lat == 4, overflow2, carry_out2, result2} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d v=%b c=%b res=%h, want lat=4 v=%b c=%b res=%h",
               lat, overflow2, carry_out2, result2, exp[9], exp[8], exp[7:0]);
    end
    release_result2();
  endtask

  task automatic test_sweep(input int n_ops);
    logic [7:0] x, y;
    logic       s;
    logic [9:0] exp;
    int lat1, lat2, lat8;
    for (int i = 0; i < n_ops; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      if (i == 0) begin x = 8'h80; y = 8'h80; s = 1'b0; end
      exp = ref_model(x, y, s);
      a = x; b = y; sub = s;
      in_valid1 = 1'b1; in_valid2 = 1'b1; in_valid8 = 1'b1;
      tick();
      in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid8 = 1'b0;
      lat1 = 0; lat2 = 0; lat8 = 0;
      for (int k = 1; k <= 20; k++) begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        tick();
        if (out_valid1 && lat1 == 0) lat1 = k;
        if (out_valid2 && lat2 == 0) lat2 = k;
        if (out_valid8 && lat8 == 0) lat8 = k;
        if (lat1 != 0 && lat2 != 0 && lat8 != 0) break;
      end
      checks++;
      if ({lat1 == 8, lat2 == 4, lat8 == 1} !== 3'b111) begin
        errors++;
        $display("FAIL sweep_latency[%0d]: d1=%0d d2=%0d d8=%0d, want 8 4 1", i, lat1, lat2, lat8);
      end
      checks++;
      if ({overflow1, carry_out1, result1} !== exp) begin
        errors++;
        $display("FAIL sweep_d1[%0d] %h %s %h: v=%b c=%b res=%h, want v=%b c=%b res=%h", i, x,
                 s ? "-" : "+", y, overflow1, carry_out1, result1, exp[9], exp[8], exp[7:0]);
      end
      checks++;
      if ({overflow2, carry_out2, result2} !== exp) begin
        errors++;
        $display("FAIL sweep_d2[%0d] %h %s %h: v=%b c=%b res=%h, want v=%b c=%b res=%h", i, x,
                 s ? "-" : "+", y, overflow2, carry_out2, result2, exp[9], exp[8], exp[7:0]);
      end
      checks++;
      if ({overflow8, carry_out8, result8} !== exp) begin
        errors++;
        $display("FAIL sweep_d8[%0d] %h %s %h: v=%b c=%b res=%h, want v=%b c=%b res=%h", i, x,
                 s ? "-" : "+", y, overflow8, carry_out8, result8, exp[9], exp[8], exp[7:0]);
      end
      out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready8 = 1'b1;
      tick();
      out_ready1 = 1'b0; out_ready2 = 1'b0; out_ready8 = 1'b0;
      checks++;
      if ({in_ready1, in_ready2, in_ready8} !== 3'b111) begin
        errors++;
        $display("FAIL sweep_idle[%0d]: rdy d1=%b d2=%b d8=%b, want all 1", i, in_ready1, in_ready2, in_ready8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_sweep(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
